mig_tt_sweep_checker: RTL

- Exhaustive truth-table sweep stage for the majority-gate combinational netlists.
- Drives every input vector in ascending binary order onto the netlist primary inputs and samples the netlist output after a programmable settle window.
- Packs the samples into a captured truth table and compares it against an expected constant.
- Acts as both upstream stimulus source and downstream consumer for one netlist instance; reports pass/fail, mismatch count and first failing index.

---
 rtl/mig_tt_sweep_checker.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/mig_tt_sweep_checker.sv
// ---------------------------------------------------------------------------
// mig_tt_sweep_checker
//
// Exhaustive truth-table sweep for one majority-gate combinational netlist.
// Every input vector is driven onto the netlist in ascending binary order.
// Each vector is held for SETTLE_CYC clocks plus one SAMPLE clock, and then
// the netlist output is sampled. The samples are packed into tt_o and compared
// bit by bit against EXP_TT.
//
// Optional feature macro: MIG_SWEEP_STOP_ON_FAIL_EN
//   defined   : the first mismatching sample ends the sweep (straight to DONE)
//   undefined : the full sweep of 2**NUM_PI vectors always runs
//
// Ports:
//   clk           in   1          sole clock, rising edge
//   rst_n         in   1          asynchronous active-low reset
//   start         in   1          level, sampled only in IDLE; launches a sweep
//   pi_o          out  NUM_PI     vector driven to the netlist primary inputs
//   po_i          in   1          netlist output, combinational from pi_o
//   busy          out  1          high in SETTLE/SAMPLE, low in IDLE/DONE
//   done          out  1          one-cycle pulse when the sweep completes
//   pass          out  1          captured table matched EXP_TT
//   tt_o          out  2**NUM_PI  captured truth table
//   err_cnt       out  NUM_PI+1   number of mismatching table bits
//   first_err_idx out  NUM_PI     lowest mismatching vector index (0 if none)
// ---------------------------------------------------------------------------
module mig_tt_sweep_checker #(
    parameter int                      NUM_PI     = 4,
    parameter int                      SETTLE_CYC = 2,
    parameter logic [(2**NUM_PI)-1:0]  EXP_TT     = 16'h0888
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    output logic [NUM_PI-1:0]         pi_o,
    input  logic                      po_i,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic [(2**NUM_PI)-1:0]    tt_o,
    output logic [NUM_PI:0]           err_cnt,
    output logic [NUM_PI-1:0]         first_err_idx
);

    localparam int                NVEC        = 2**NUM_PI;
    localparam int                CNT_W       = 4;
    localparam logic [CNT_W-1:0]  CNT_ZERO    = CNT_W'(0);
    localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [NUM_PI-1:0] IDX_ZERO    = NUM_PI'(0);
    localparam logic [NUM_PI-1:0] IDX_ONE     = NUM_PI'(1);
    localparam logic [NUM_PI-1:0] IDX_LAST    = NUM_PI'(NVEC - 1);
    localparam logic [NUM_PI:0]   ERR_ZERO    = (NUM_PI+1)'(0);
    localparam logic [NUM_PI:0]   ERR_ONE     = (NUM_PI+1)'(1);
    localparam logic [NUM_PI:0]   ERR_MAX     = (NUM_PI+1)'(NVEC);
    localparam logic [NVEC-1:0]   TT_ZERO     = NVEC'(0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t              state_q;
    logic [NUM_PI-1:0]   idx_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [NUM_PI-1:0]   pi_q;
    logic                busy_q;
    logic                done_q;
    logic                pass_q;
    logic [NVEC-1:0]     tt_q;
    logic [NUM_PI:0]     err_cnt_q;
    logic [NUM_PI:0]     err_cnt_d;
    logic [NUM_PI-1:0]   first_err_idx_q;

    logic                mismatch_s;

    // Compare the live netlist output against the expected bit for this vector.
    always_comb begin
        mismatch_s = 1'b0;
        if (po_i != EXP_TT[idx_q]) begin
            mismatch_s = 1'b1;
        end else begin
            mismatch_s = 1'b0;
        end
    end

    // Next mismatch count; saturates at the table size so it can never wrap.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (mismatch_s && (err_cnt_q != ERR_MAX)) begin
            err_cnt_d = err_cnt_q + ERR_ONE;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // Sweep FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            idx_q           <= IDX_ZERO;
            cnt_q           <= CNT_ZERO;
            pi_q            <= IDX_ZERO;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            pass_q          <= 1'b0;
            tt_q            <= TT_ZERO;
            err_cnt_q       <= ERR_ZERO;
            first_err_idx_q <= IDX_ZERO;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        idx_q           <= IDX_ZERO;
                        cnt_q           <= CNT_ZERO;
                        pi_q            <= IDX_ZERO;
                        tt_q            <= TT_ZERO;
                        err_cnt_q       <= ERR_ZERO;
                        first_err_idx_q <= IDX_ZERO;
                        pass_q          <= 1'b0;
                        busy_q          <= 1'b1;
                        state_q         <= S_SETTLE;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end

                S_SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_q <= S_SAMPLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end

                S_SAMPLE: begin
                    tt_q[idx_q] <= po_i;
                    err_cnt_q   <= err_cnt_d;
                    // First mismatch of the sweep: nothing counted yet.
                    if (mismatch_s && (err_cnt_q == ERR_ZERO)) begin
                        first_err_idx_q <= idx_q;
                    end else begin
                        first_err_idx_q <= first_err_idx_q;
                    end
`ifdef MIG_SWEEP_STOP_ON_FAIL_EN
                    if (mismatch_s || (idx_q == IDX_LAST)) begin
`else
                    if (idx_q == IDX_LAST) begin
`endif
                        // pass uses the post-sample count so it is valid with done.
                        pass_q  <= (err_cnt_d == ERR_ZERO);
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_DONE;
                    end else begin
                        // pi_o moves only here, giving SETTLE_CYC+1 stable cycles.
                        idx_q   <= idx_q + IDX_ONE;
                        pi_q    <= idx_q + IDX_ONE;
                        cnt_q   <= CNT_ZERO;
                        state_q <= S_SETTLE;
                    end
                end

                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign pi_o          = pi_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign tt_o          = tt_q;
    assign err_cnt       = err_cnt_q;
    assign first_err_idx = first_err_idx_q;

endmodule
